// File: rtl/mcb_write_arbiter_if.sv
// mcb_write_arbiter_if
//   Bundles the client-side word-write handshake and the MCB write-port
//   signals (command FIFO + write-data FIFO) shared by mcb_write_arbiter.
//   Client fields are flat vectors, one slice per client:
//     cli_req   [N]     client i has a word pending (held until ack)
//     cli_addr  [30*N]  byte address, bits [1:0] ignored
//     cli_data  [32*N]  write word
//     cli_mask  [4*N]   byte mask, 1 = byte not written
//     cli_ack   [N]     one-cycle pulse: word taken into the wr FIFO
//   MCB fields: mem_cmd_en/instr/bl/byte_addr/full, mem_wr_en/data/mask/full,
//   mem_wr_underrun, mem_wr_error.
//   Modports: slave = arbiter view, master = clients + MCB view.
interface mcb_write_arbiter_if #(
  parameter int NUM_CLIENTS = 2
);
  logic [NUM_CLIENTS-1:0]    cli_req;
  logic [30*NUM_CLIENTS-1:0] cli_addr;
  logic [32*NUM_CLIENTS-1:0] cli_data;
  logic [4*NUM_CLIENTS-1:0]  cli_mask;
  logic [NUM_CLIENTS-1:0]    cli_ack;

  logic        mem_cmd_en;
  logic [2:0]  mem_cmd_instr;
  logic [5:0]  mem_cmd_bl;
  logic [29:0] mem_cmd_byte_addr;
  logic        mem_cmd_full;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_mask;
  logic        mem_wr_full;
  logic        mem_wr_underrun;
  logic        mem_wr_error;

  modport slave (
    input  cli_req, cli_addr, cli_data, cli_mask,
    output cli_ack,
    output mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr,
    input  mem_cmd_full,
    output mem_wr_en, mem_wr_data, mem_wr_mask,
    input  mem_wr_full, mem_wr_underrun, mem_wr_error
  );

  modport master (
    output cli_req, cli_addr, cli_data, cli_mask,
    input  cli_ack,
    input  mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr,
    output mem_cmd_full,
    input  mem_wr_en, mem_wr_data, mem_wr_mask,
    output mem_wr_full, mem_wr_underrun, mem_wr_error
  );
endinterface

// File: rtl/mcb_write_arbiter.sv
// mcb_write_arbiter
//   Shares one MCB write port between NUM_CLIENTS word-write clients.
//   A client is granted round-robin; runs of consecutive word addresses from
//   that client are pushed into the MCB wr FIFO and closed with a single
//   write command of up to MAX_BURST words.
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mcb_write_arbiter_if.slave: client handshake + MCB cmd/wr FIFOs
//   err    sticky flag, set by mem_wr_underrun or mem_wr_error
module mcb_write_arbiter #(
  parameter int NUM_CLIENTS = 2,
  parameter int MAX_BURST   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mcb_write_arbiter_if.slave bus,
  output logic               err
);
  localparam int GW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, FILL, CMD} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] rr_ptr, grant, pick;
  logic [CW-1:0] count;
  // Addresses are tracked as 28-bit word addresses; byte bits are implied 0.
  logic [27:0]   base_word, next_word, pick_word, g_word;
  logic [31:0]   g_data;
  logic [3:0]    g_mask;
  logic          g_req, accept, cmd_fire;
  logic [5:0]    cmd_bl;
  logic [29:0]   cmd_addr;

  // First requester at or after ptr, scanning circularly.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_CLIENTS-1:0] req,
                                            input logic [GW-1:0] ptr);
    int idx;
    rr_pick = ptr;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CLIENTS) idx -= NUM_CLIENTS;
      if (req[idx]) rr_pick = GW'(idx);
    end
  endfunction

  function automatic logic [GW-1:0] rr_next(input logic [GW-1:0] g);
    int n;
    n = int'(g) + 1;
    if (n >= NUM_CLIENTS) n = 0;
    return GW'(n);
  endfunction

  always_comb begin
    pick      = rr_pick(bus.cli_req, rr_ptr);
    pick_word = bus.cli_addr[int'(pick)*30 + 2 +: 28];
    g_req     = bus.cli_req[grant];
    g_word    = bus.cli_addr[int'(grant)*30 + 2 +: 28];
    g_data    = bus.cli_data[int'(grant)*32 +: 32];
    g_mask    = bus.cli_mask[int'(grant)*4 +: 4];
    // A zero next_word with words already taken means the burst would wrap
    // the address space; that word has to start a fresh burst.
    accept    = (state == FILL) && g_req && !bus.mem_wr_full &&
                (g_word == next_word) && (count < CW'(MAX_BURST)) &&
                ((count == '0) || (next_word != '0));
    cmd_fire  = (state == CMD) && !bus.mem_cmd_full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (|bus.cli_req) state_nxt = FILL;
      FILL: begin
        if (accept)                         state_nxt = FILL;
        else if (count != '0)               state_nxt = CMD;
        else if (g_req && bus.mem_wr_full)  state_nxt = FILL;
        else                                state_nxt = IDLE;
      end
      CMD:  if (cmd_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_cmd_en        = cmd_fire;
    bus.mem_cmd_instr     = 3'b000;
    bus.mem_cmd_bl        = cmd_bl;
    bus.mem_cmd_byte_addr = cmd_addr;
    bus.mem_wr_en         = accept;
    bus.mem_wr_data       = (state == FILL) ? g_data : '0;
    bus.mem_wr_mask       = (state == FILL) ? g_mask : '0;
    for (int i = 0; i < NUM_CLIENTS; i++)
      bus.cli_ack[i] = accept && (int'(grant) == i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      grant    <= '0;
      count    <= '0;
      cmd_bl   <= '0;
      cmd_addr <= '0;
      err      <= 1'b0;
    end else begin
      if (bus.mem_wr_underrun || bus.mem_wr_error) err <= 1'b1;
      case (state)
        IDLE: if (|bus.cli_req) begin
          grant <= pick;
          count <= '0;
        end
        FILL: begin
          if (accept) begin
            count <= count + CW'(1);
          end else if (count != '0) begin
            // Command fields frozen here so they stay stable through CMD.
            cmd_bl   <= 6'(count - CW'(1));
            cmd_addr <= {base_word, 2'b00};
          end
        end
        CMD: if (cmd_fire) rr_ptr <= rr_next(grant);
        default: ;
      endcase
    end
  end

  // Address tracking is only meaningful once a grant is taken.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      base_word <= pick_word;
      next_word <= pick_word;
    end else if (accept) begin
      next_word <= next_word + 28'd1;
    end
  end
endmodule
